// File: rtl/spi_slave_core.sv
// SPI slave core: synchronised SPI pins, one-word TX buffer, RX word handshake.
// Latency: rx_valid rises SYNC_STAGES+2 clk edges after the raw sck sample edge of the last bit.
// Backpressure: rx side is valid/ready, and a word completing while rx_valid && !rx_ready is
// dropped with an overrun pulse. tx_ready is high while the TX buffer is empty; a word that
// starts with the buffer empty sends zeros and pulses underrun.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cs_n, sck, mosi       raw SPI pins (asynchronous to clk)
//   miso                  serial data out (0 while deselected)
//   tx_data/valid/ready   TX buffer write port
//   rx_data/valid/ready   received word handshake
//   overrun, underrun     one-cycle error pulses
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              underrun
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic              IDLE_LVL = (CPOL != 0);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam int                OUT_IDX  = (MSB_FIRST != 0) ? DATA_W - 1 : 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_s, sck_s, mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sck_sync  <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Edge detection. sck edges are registered into pulses together with
  // mosi, so the sampled data bit is exactly the one present at the edge.
  // ---------------------------------------------------------------
  logic cs_q, sck_q;
  logic sck_lead, sck_trail;
  logic sample_p, shift_p, mosi_p;
  logic cs_fall, cs_rise;

  assign sck_lead  = (sck_q == IDLE_LVL) && (sck_s != IDLE_LVL);
  assign sck_trail = (sck_q != IDLE_LVL) && (sck_s == IDLE_LVL);
  assign cs_fall   = cs_q && !cs_s;
  assign cs_rise   = !cs_q && cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 1'b0;
      sck_q    <= IDLE_LVL;
      sample_p <= 1'b0;
      shift_p  <= 1'b0;
      mosi_p   <= 1'b0;
    end else begin
      cs_q     <= cs_s;
      sck_q    <= sck_s;
      sample_p <= (CPHA != 0) ? sck_trail : sck_lead;
      shift_p  <= (CPHA != 0) ? sck_lead  : sck_trail;
      mosi_p   <= mosi_s;
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_start, frame_end, do_sample, do_shift, word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else begin
          do_sample = sample_p;
          do_shift  = shift_p;
          word_done = sample_p && (bit_cnt == LAST_BIT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] tx_buf, tx_shift, tx_adv;
  logic [DATA_W-1:0] rx_shift, rx_next;
  logic              tx_full, tx_starved, tx_load;

  assign tx_load  = frame_start || word_done;
  assign tx_ready = !tx_full;

  assign rx_next = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_p}
                                    : {mosi_p, rx_shift[DATA_W-1:1]};
  assign tx_adv  = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_shift[DATA_W-1:1]};

  assign miso = (state_q == ACTIVE) ? tx_shift[OUT_IDX] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      tx_shift   <= '0;
      tx_starved <= 1'b0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;

      // Transmit. The shift edge following a word load (bit_cnt == 0) must
      // not advance: for CPHA=1 it is the edge that presents bit 0, for
      // CPHA=0 it trails the sample edge that just completed the old word.
      if (tx_load) begin
        tx_shift   <= tx_full ? tx_buf : '0;
        tx_starved <= !tx_full;
        tx_full    <= 1'b0;
      end else if (do_shift && (bit_cnt != '0)) begin
        tx_shift <= tx_adv;
      end
      // Accept only when empty, so this never collides with a non-empty load.
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      // Receive. A starved word reports underrun only once it actually
      // starts clocking, so the trailing load at the end of a frame is silent.
      if (frame_start || frame_end) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (do_sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        if ((bit_cnt == '0) && tx_starved) underrun <= 1'b1;
      end

      // Handshake: a consume on the completion cycle frees the slot.
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;

  localparam int NI = 8;  // index bit2=CPOL, bit1=CPHA, bit0=LSB-first

  logic       clk = 1'b0;
  logic       rst_n, cs_n, sck_base, mosi, tx_valid, rx_ready;
  logic [7:0] tx_data;

  logic       miso_a     [NI];
  logic       tx_ready_a [NI];
  logic [7:0] rx_data_a  [NI];
  logic       rx_valid_a [NI];
  logic       ovr_a      [NI];
  logic       unr_a      [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam bit POL = (g >= 4);
      spi_slave_core #(
        .DATA_W(8), .CPOL(g / 4), .CPHA((g / 2) % 2),
        .MSB_FIRST(1 - (g % 2)), .SYNC_STAGES(2)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck_base ^ POL),
        .mosi(mosi), .miso(miso_a[g]),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_a[g]),
        .rx_data(rx_data_a[g]), .rx_valid(rx_valid_a[g]), .rx_ready(rx_ready),
        .overrun(ovr_a[g]), .underrun(unr_a[g])
      );
    end
  endgenerate

  int total = 0, bad = 0;
  int cyc = 0, samp_cyc = 0, rise_cyc = 0, rise_cnt = 0, ovr_cnt = 0, unr_cnt = 0;
  logic        prev_rv = 1'b0;
  logic [7:0]  rxq [$];
  logic [31:0] cap [NI];

  always @(posedge clk) cyc++;

  // Observe instance 0 away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_a[0] && !prev_rv) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (rx_valid_a[0] && rx_ready) rxq.push_back(rx_data_a[0]);
      if (ovr_a[0]) ovr_cnt++;
      if (unr_a[0]) unr_cnt++;
    end
    prev_rv = rx_valid_a[0];
  end

  function automatic bit cpha_of(input int k);
    return ((k / 2) % 2) == 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k % 2) == 0;
  endfunction

  function automatic logic [7:0] q_at(input int idx);
    return (rxq.size() > idx) ? rxq[idx] : 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(1);
  endtask

  task automatic start_frame();
    for (int k = 0; k < NI; k++) cap[k] = '0;
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    tick(4);
    cs_n = 1'b1;
    tick(10);
  endtask

  // Master: mosi is stable across both edges of each bit, so every mode
  // samples the same bit; miso is captured at each instance's sample edge.
  task automatic send_bits(input logic [7:0] w, input int nbits, input bit rdy_at_done);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      tick(4);
      for (int k = 0; k < NI; k++) if (!cpha_of(k)) cap[k] = {cap[k][30:0], miso_a[k]};
      sck_base = 1'b1;
      if (i == nbits - 1) samp_cyc = cyc;
      if (rdy_at_done && i == nbits - 1) begin
        tick(3);
        rx_ready = 1'b1;
        tick(5);
      end else begin
        tick(8);
      end
      for (int k = 0; k < NI; k++) if (cpha_of(k)) cap[k] = {cap[k][30:0], miso_a[k]};
      sck_base = 1'b0;
      tick(4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck_base = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
    tick(3);
    for (int k = 0; k < NI; k++) begin
      total++; if (miso_a[k] !== 1'b0) begin bad++; $display("FAIL reset_miso[%0d]: got %b want 0", k, miso_a[k]); end
      total++; if (tx_ready_a[k] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready[%0d]: got %b want 1", k, tx_ready_a[k]); end
      total++; if (rx_valid_a[k] !== 1'b0) begin bad++; $display("FAIL reset_rx_valid[%0d]: got %b want 0", k, rx_valid_a[k]); end
      total++; if (rx_data_a[k] !== 8'h00) begin bad++; $display("FAIL reset_rx_data[%0d]: got %h want 00", k, rx_data_a[k]); end
      total++; if (ovr_a[k] !== 1'b0 || unr_a[k] !== 1'b0) begin bad++; $display("FAIL reset_pulses[%0d]: got %b%b want 00", k, ovr_a[k], unr_a[k]); end
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_mode0();
    int base = rxq.size();
    int u0 = unr_cnt;
    int o0 = ovr_cnt;
    tx_push(8'hA5);
    total++; if (tx_ready_a[0] !== 1'b0) begin bad++; $display("FAIL m0_tx_full: got %b want 0", tx_ready_a[0]); end
    start_frame();
    send_bits(8'h3C, 8, 1'b0);
    end_frame();
    total++; if (cap[0][7:0] !== 8'hA5) begin bad++; $display("FAIL m0_miso: got %h want a5", cap[0][7:0]); end
    total++; if (rxq.size() != base + 1) begin bad++; $display("FAIL m0_rx_count: got %0d want %0d", rxq.size(), base + 1); end
    total++; if (q_at(base) !== 8'h3C) begin bad++; $display("FAIL m0_rx_data: got %h want 3c", q_at(base)); end
    total++; if (rise_cyc - samp_cyc != 4) begin bad++; $display("FAIL m0_latency: got %0d want 4", rise_cyc - samp_cyc); end
    total++; if (unr_cnt != u0 || ovr_cnt != o0) begin bad++; $display("FAIL m0_pulses: got unr %0d ovr %0d want 0 0", unr_cnt - u0, ovr_cnt - o0); end
    total++; if (miso_a[0] !== 1'b0) begin bad++; $display("FAIL m0_idle_miso: got %b want 0", miso_a[0]); end
  endtask

  task automatic test_modes();
    logic [7:0] exp_cap;
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(4);
    tx_push(8'hC1);
    start_frame();
    send_bits(8'h81, 8, 1'b0);
    end_frame();
    for (int k = 0; k < NI; k++) begin
      exp_cap = msb_of(k) ? 8'hC1 : 8'h83;
      total++; if (rx_data_a[k] !== 8'h81) begin bad++; $display("FAIL modes_rx[%0d]: got %h want 81", k, rx_data_a[k]); end
      total++; if (cap[k][7:0] !== exp_cap) begin bad++; $display("FAIL modes_miso[%0d]: got %h want %h", k, cap[k][7:0], exp_cap); end
    end
  endtask

  task automatic test_back_to_back();
    int base = rxq.size();
    int u0 = unr_cnt;
    int r0 = rise_cnt;
    tx_push(8'hC3);
    start_frame();
    total++; if (tx_ready_a[0] !== 1'b1) begin bad++; $display("FAIL b2b_loaded: got %b want 1", tx_ready_a[0]); end
    tx_push(8'h5A);
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    end_frame();
    total++; if (cap[0][15:0] !== 16'hC35A) begin bad++; $display("FAIL b2b_miso: got %h want c35a", cap[0][15:0]); end
    total++; if (q_at(base) !== 8'h11 || q_at(base + 1) !== 8'h22) begin bad++; $display("FAIL b2b_rx: got %h %h want 11 22", q_at(base), q_at(base + 1)); end
    total++; if (rise_cnt - r0 != 2) begin bad++; $display("FAIL b2b_valid_count: got %0d want 2", rise_cnt - r0); end
    total++; if (unr_cnt != u0) begin bad++; $display("FAIL b2b_underrun: got %0d want 0", unr_cnt - u0); end
  endtask

  task automatic test_overrun();
    int base = rxq.size();
    int o0 = ovr_cnt;
    rx_ready = 1'b0;
    start_frame();
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'hAA, 8, 1'b0);
    end_frame();
    total++; if (rx_valid_a[0] !== 1'b1 || rx_data_a[0] !== 8'h55) begin bad++; $display("FAIL ovr_hold: got %b %h want 1 55", rx_valid_a[0], rx_data_a[0]); end
    total++; if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
    rx_ready = 1'b1;
    tick(2);
    total++; if (q_at(base) !== 8'h55 || rx_valid_a[0] !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %h %b want 55 0", q_at(base), rx_valid_a[0]); end

    base = rxq.size();
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    start_frame();
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'hAA, 8, 1'b1);
    end_frame();
    total++; if (q_at(base) !== 8'h55 || q_at(base + 1) !== 8'hAA) begin bad++; $display("FAIL ovr_same_cycle: got %h %h want 55 aa", q_at(base), q_at(base + 1)); end
    total++; if (ovr_cnt != o0) begin bad++; $display("FAIL ovr_same_cycle_pulse: got %0d want 0", ovr_cnt - o0); end
    rx_ready = 1'b1;
  endtask

  task automatic test_underrun_abort();
    int base = rxq.size();
    int u0 = unr_cnt;
    int r0;
    total++; if (tx_ready_a[0] !== 1'b1) begin bad++; $display("FAIL ur_empty: got %b want 1", tx_ready_a[0]); end
    start_frame();
    send_bits(8'hF0, 8, 1'b0);
    end_frame();
    total++; if (cap[0][7:0] !== 8'h00) begin bad++; $display("FAIL ur_miso: got %h want 00", cap[0][7:0]); end
    total++; if (unr_cnt - u0 != 1) begin bad++; $display("FAIL ur_pulse: got %0d want 1", unr_cnt - u0); end
    total++; if (q_at(base) !== 8'hF0) begin bad++; $display("FAIL ur_rx: got %h want f0", q_at(base)); end

    base = rxq.size();
    r0 = rise_cnt;
    start_frame();
    send_bits(8'hFF, 5, 1'b0);
    end_frame();
    total++; if (rise_cnt != r0 || rxq.size() != base) begin bad++; $display("FAIL abort_no_valid: got %0d words want 0", rise_cnt - r0); end

    tx_push(8'h3C);
    start_frame();
    send_bits(8'h96, 8, 1'b0);
    end_frame();
    total++; if (q_at(base) !== 8'h96) begin bad++; $display("FAIL abort_next_rx: got %h want 96", q_at(base)); end
    total++; if (cap[0][7:0] !== 8'h3C) begin bad++; $display("FAIL abort_next_miso: got %h want 3c", cap[0][7:0]); end
  endtask

  task automatic test_reset_midword();
    int base;
    int r0;
    tx_push(8'hFF);
    start_frame();
    tx_push(8'h77);
    send_bits(8'hFF, 4, 1'b0);
    total++; if (miso_a[0] !== 1'b1 || tx_ready_a[0] !== 1'b0) begin bad++; $display("FAIL rstmid_pre: got %b %b want 1 0", miso_a[0], tx_ready_a[0]); end
    rst_n = 1'b0;
    #1;
    total++; if (miso_a[0] !== 1'b0 || tx_ready_a[0] !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b %b want 0 1", miso_a[0], tx_ready_a[0]); end
    total++; if (rx_valid_a[0] !== 1'b0 || rx_data_a[0] !== 8'h00) begin bad++; $display("FAIL rstmid_rx: got %b %h want 0 00", rx_valid_a[0], rx_data_a[0]); end
    total++; if (ovr_a[0] !== 1'b0 || unr_a[0] !== 1'b0) begin bad++; $display("FAIL rstmid_pulses: got %b%b want 00", ovr_a[0], unr_a[0]); end
    tick(2);
    rst_n = 1'b1;
    tick(4);
    // cs_n is still low: without a fresh falling edge the clocks are ignored.
    r0 = rise_cnt;
    send_bits(8'hFF, 8, 1'b0);
    tick(6);
    total++; if (rise_cnt != r0 || miso_a[0] !== 1'b0) begin bad++; $display("FAIL rstmid_ignored: got %0d words miso %b want 0 0", rise_cnt - r0, miso_a[0]); end
    cs_n = 1'b1;
    tick(10);
    base = rxq.size();
    tx_push(8'hE7);
    start_frame();
    send_bits(8'h42, 8, 1'b0);
    end_frame();
    total++; if (q_at(base) !== 8'h42) begin bad++; $display("FAIL rstmid_next_rx: got %h want 42", q_at(base)); end
    total++; if (cap[0][7:0] !== 8'hE7) begin bad++; $display("FAIL rstmid_next_miso: got %h want e7", cap[0][7:0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_underrun_abort();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 8: bits per SPI word; legal range 4..32.
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = bit DATA_W-1 first; 0 = bit 0 first.
- SYNC_STAGES, 2: synchroniser depth on cs_n/sck/mosi; legal range 2..3.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single system clock; all state is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- cs_n, in, 1: chip select, active low, asynchronous to clk.
- sck, in, 1: SPI clock, asynchronous to clk.
- mosi, in, 1: serial data in.
- miso, out, 1: serial data out.
- tx_data, in, DATA_W: next word to transmit.
- tx_valid, in, 1: tx_data valid.
- tx_ready, out, 1: TX buffer empty.
- rx_data, out, DATA_W: received word.
- rx_valid, out, 1: rx_data valid.
- rx_ready, in, 1: consumer accepts rx_data.
- overrun, out, 1: one-cycle pulse; received word dropped.
- underrun, out, 1: one-cycle pulse; word started with TX buffer empty.

Function
REQ-003 cs_n, sck and mosi shall each pass through SYNC_STAGES flops; all logic shall use only the synchronised copies.
REQ-004 Edge detection on synchronised sck: leading edge = departure from CPOL level, trailing edge = return to it; sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
REQ-005 FSM states: IDLE and ACTIVE. IDLE->ACTIVE on synchronised cs_n falling. ACTIVE->IDLE on synchronised cs_n rising. sck edges in IDLE shall be ignored.
REQ-006 TX buffer: one DATA_W register. tx_ready=1 when empty. A word is accepted when tx_valid && tx_ready at a clk edge.
REQ-007 Word load: on entering ACTIVE, and on the sample edge that completes a word, the TX buffer shall move into the TX shift register and the buffer shall become empty.
REQ-008 If the TX buffer is empty at word load, the shift register shall load all-zeros and underrun shall pulse for 1 cycle.
REQ-009 miso shall be 0 in IDLE.
REQ-010 In ACTIVE, miso shall present the current output bit, in MSB_FIRST order; it shall advance only on shift edges.
REQ-011 With CPHA=0, bit 0 of the word shall be on miso before the first leading edge.
REQ-012 With CPHA=1, the first leading edge shall present the first bit (no advance).
REQ-013 Each sample edge shall shift the synchronised mosi into the RX shift register in MSB_FIRST order and increment a bit counter.
REQ-014 The bit counter shall wrap at DATA_W, allowing back-to-back words in one cs_n frame.
REQ-015 Word complete (counter = DATA_W-1 at a sample edge), rx_valid=0: rx_data shall load the word and rx_valid shall go high on the next clk edge.
REQ-016 Word complete with rx_valid=1 and rx_ready=0: the new word shall be dropped, rx_data shall be unchanged, and overrun shall pulse for 1 cycle.
REQ-017 Word complete on the same cycle that rx_valid && rx_ready: this shall count as a consume, the new word shall load, and overrun shall not pulse.
REQ-018 rx_valid shall clear on the clk edge where rx_valid && rx_ready, unless REQ-017 applies.
REQ-019 cs_n rising mid-word: the partial RX word shall be discarded with no rx_valid. The bit counter shall reset to 0. The TX word already loaded shall be lost; the buffer shall not be restored.
REQ-020 Timing: clk shall be at least 4x sck; each sck level shall be held for at least SYNC_STAGES+1 clk cycles.
REQ-021 Latency: rx_valid shall rise exactly SYNC_STAGES+2 rising clk edges after the raw sck sample edge of the last bit.

Reset
REQ-022 rst_n low shall asynchronously force: state IDLE; miso=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, underrun=0; counters, shift registers and synchronisers cleared to 0, except the sck synchroniser, which clears to CPOL.
REQ-023 Reset asserted mid-frame shall abort the frame; after release, the block shall wait for a fresh cs_n falling edge.

Verification
REQ-024 Mode 0, DATA_W=8: tx 0xA5 preloaded; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid after SYNC_STAGES+2 clk; no underrun.
REQ-025 Loop CPOL/CPHA over all 4 modes and MSB_FIRST over 0/1; master sends 0x81 -> rx_data=0x81 in every mode; LSB-first miso order reversed versus MSB-first.
REQ-026 Two back-to-back words 0x11, 0x22 in one frame; TX buffer refilled between them -> two rx_valid handshakes; miso carries both TX words with no gap bit.
REQ-027 rx_ready held 0 across two words 0x55, 0xAA -> rx_data stays 0x55; overrun pulses once. Same test with rx_ready rising on the completion cycle -> 0xAA accepted; no overrun.
REQ-028 Frame with empty TX buffer -> miso all 0; underrun pulses once. cs_n raised after 5 bits -> no rx_valid; next frame receives correctly.
REQ-029 rst_n asserted mid-word -> all outputs at reset values within the same cycle; subsequent full frame is correct.
